// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared parameters and types for the ROB slot allocator.
// Slot pointers are {wrap, row, bank}. Since the bank count is a power of two,
// a pointer is also a plain binary slot counter modulo 2*ROB_ROWS*DISPATCH_WIDTH.
package rob_alloc_ctrl_pkg;

    localparam int DISPATCH_WIDTH      = 2;
    localparam int ROB_ROWS            = 16;
    localparam int ROB_ADDR_WIDTH      = $clog2(ROB_ROWS);
    localparam int DISPATCH_ADDR_WIDTH = $clog2(DISPATCH_WIDTH);
    localparam int MAX_BRANCHES        = 8;

    typedef struct packed {
        logic                           wrap;
        logic [ROB_ADDR_WIDTH-1:0]      row;
        logic [DISPATCH_ADDR_WIDTH-1:0] bank;
    } rob_slot_ptr_t;

    // Population count of a lane mask (callers zero-extend to 32 bits).
    function automatic int count_ones(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch/commit handshake between rename and the ROB slot allocator.
// master: rename/dispatch + commit side; slave: the allocator.
interface rob_alloc_ctrl_if
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int DISPATCH_WIDTH = rob_alloc_ctrl_pkg::DISPATCH_WIDTH,
    parameter int ROB_ROWS       = rob_alloc_ctrl_pkg::ROB_ROWS,
    parameter int MAX_BRANCHES   = rob_alloc_ctrl_pkg::MAX_BRANCHES
) ();

    localparam int RA = $clog2(ROB_ROWS);
    localparam int BA = $clog2(DISPATCH_WIDTH);
    localparam int CW = BA + 1;
    localparam int FW = $clog2(ROB_ROWS * DISPATCH_WIDTH) + 1;
    localparam int BW = $clog2(MAX_BRANCHES) + 1;

    logic [DISPATCH_WIDTH-1:0]         disp_en;
    logic [DISPATCH_WIDTH-1:0]         disp_is_branch;
    logic [DISPATCH_WIDTH-1:0][RA-1:0] alloc_rob_addr;
    logic [DISPATCH_WIDTH-1:0][BA-1:0] alloc_bank_addr;
    logic                              full;
    logic                              empty;
    logic [CW-1:0]                     commit_cnt;
    logic [CW-1:0]                     commit_br_cnt;
    logic                              flush;
    logic [RA-1:0]                     head_row;
    logic [BA-1:0]                     head_bank;
    logic [FW-1:0]                     free_slots;
    logic [BW-1:0]                     br_inflight;

    modport master (
        output disp_en, disp_is_branch, commit_cnt, commit_br_cnt, flush,
        input  alloc_rob_addr, alloc_bank_addr, full, empty,
               head_row, head_bank, free_slots, br_inflight
    );

    modport slave (
        input  disp_en, disp_is_branch, commit_cnt, commit_br_cnt, flush,
        output alloc_rob_addr, alloc_bank_addr, full, empty,
               head_row, head_bank, free_slots, br_inflight
    );

endinterface

// File: rtl/rob_alloc_ctrl_chk.sv
// Protocol checker for the ROB slot allocator: commit legality and,
// with ROB_BRANCH_LIMIT_EN, branch-retire legality.
module rob_alloc_ctrl_chk #(
    parameter int LANES = 2,
    parameter int SW    = 6,
    parameter int CW    = 2,
    parameter int BW    = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    input logic [CW-1:0] commit_cnt,
    input logic [CW-1:0] commit_br_cnt,
    input logic [SW-1:0] occ,
    input logic [BW-1:0] br_inflight
);

    a_commit_le_occ: assert property (@(posedge clk) disable iff (!rst_n)
        !flush |-> (int'(commit_cnt) <= int'(occ)))
        else $error("commit_cnt exceeds occupancy");

    a_commit_le_lanes: assert property (@(posedge clk) disable iff (!rst_n)
        int'(commit_cnt) <= LANES)
        else $error("commit_cnt exceeds dispatch width");

    a_br_le_commit: assert property (@(posedge clk) disable iff (!rst_n)
        int'(commit_br_cnt) <= int'(commit_cnt))
        else $error("commit_br_cnt exceeds commit_cnt");

`ifdef ROB_BRANCH_LIMIT_EN
    a_br_le_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        !flush |-> (int'(commit_br_cnt) <= int'(br_inflight)))
        else $error("commit_br_cnt exceeds branches in flight");
`else
    logic unused_s;
    assign unused_s = ^br_inflight;
`endif

endmodule

// File: rtl/rob_lane_compactor.sv
// Packed-slot helper: for each lane, the number of enabled lanes below it
// (its slot offset from tail), plus the total number of enabled lanes.
module rob_lane_compactor #(
    parameter int LANES = 2,
    parameter int CW    = 2
) (
    input  logic [LANES-1:0]         disp_en,
    output logic [LANES-1:0][CW-1:0] lane_off,
    output logic [CW-1:0]            total
);

    logic [CW-1:0] acc_s;

    // Exclusive prefix popcount over the lane enables, lowest lane first.
    always_comb begin
        acc_s    = '0;
        lane_off = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_off[i] = acc_s;
            acc_s       = acc_s + CW'(disp_en[i]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB slot allocator: hands out up to DISPATCH_WIDTH slots per cycle in
// program order, tracks head/tail, retires commits and handles flush.
// COMPACT=0: lane i -> bank i, one row per dispatching cycle (holes occupied).
// COMPACT=1: enabled lanes packed into consecutive slots from tail.
// Optional macro ROB_BRANCH_LIMIT_EN adds the in-flight branch counter and
// the branch-based stall.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int DISPATCH_WIDTH = rob_alloc_ctrl_pkg::DISPATCH_WIDTH,
    parameter int ROB_ROWS       = rob_alloc_ctrl_pkg::ROB_ROWS,
    parameter bit COMPACT        = 1'b0,
    parameter int MAX_BRANCHES   = rob_alloc_ctrl_pkg::MAX_BRANCHES
) (
    input logic             clk,
    input logic             rst_n,
    rob_alloc_ctrl_if.slave bus
);

    localparam int W  = DISPATCH_WIDTH;
    localparam int RA = $clog2(ROB_ROWS);
    localparam int BA = $clog2(W);
    localparam int SW = RA + BA + 1;
    localparam int CW = BA + 1;
    localparam int BW = $clog2(MAX_BRANCHES) + 1;
    localparam logic [SW-1:0] TOTAL = SW'(ROB_ROWS * W);

    typedef struct packed {
        logic          wrap;
        logic [RA-1:0] row;
        logic [BA-1:0] bank;
    } slot_ptr_t;

    slot_ptr_t               head_r, tail_r;
    slot_ptr_t               head_next_s, tail_next_s;
    logic [SW-1:0]           head_idx_s, tail_idx_s, occ_s, free_s;
    logic [W-1:0][CW-1:0]    lane_off_s;
    logic [CW-1:0]           alloc_cnt_s;
    logic [W-1:0][SW-2:0]    slot_s;
    logic                    full_s, empty_s, br_full_s;

    // Occupancy uses the wrap bit: equal row/bank with opposite wrap is full.
    assign head_idx_s = head_r;
    assign tail_idx_s = tail_r;
    assign occ_s      = tail_idx_s - head_idx_s;
    assign free_s     = TOTAL - occ_s;
    assign empty_s    = (occ_s == '0);
    // A row dispatch needs W free slots; so does a packed dispatch of up to W.
    assign full_s     = (free_s < SW'(W)) | br_full_s;

    generate
        if (COMPACT) begin : g_packed
            logic [W-1:0][CW-1:0] prefix_s;
            logic [CW-1:0]        total_s;

            rob_lane_compactor #(.LANES(W), .CW(CW)) u_compactor (
                .disp_en  (bus.disp_en),
                .lane_off (prefix_s),
                .total    (total_s)
            );

            // Packed offsets; an idle cycle shows the next W slots in order.
            always_comb begin
                lane_off_s  = prefix_s;
                alloc_cnt_s = total_s;
                if (bus.disp_en == '0) begin
                    for (int i = 0; i < W; i++) begin
                        lane_off_s[i] = CW'(i);
                    end
                end else begin
                    lane_off_s = prefix_s;
                end
            end
        end else begin : g_row
            // Row mode: tail sits on bank 0, so lane i lands on bank i.
            always_comb begin
                lane_off_s = '0;
                for (int i = 0; i < W; i++) begin
                    lane_off_s[i] = CW'(i);
                end
                if (|bus.disp_en) begin
                    alloc_cnt_s = CW'(W);
                end else begin
                    alloc_cnt_s = '0;
                end
            end
        end
    endgenerate

    // Per-lane slot address = tail + offset, modulo the ROB size.
    always_comb begin
        slot_s = '0;
        for (int i = 0; i < W; i++) begin
            slot_s[i]              = tail_idx_s[SW-2:0] + (SW-1)'(lane_off_s[i]);
            bus.alloc_rob_addr[i]  = slot_s[i][SW-2:BA];
            bus.alloc_bank_addr[i] = slot_s[i][BA-1:0];
        end
    end

    // Next head/tail: flush wins; over-commit clamps head to tail.
    always_comb begin
        head_next_s = head_r;
        tail_next_s = tail_r;
        if (bus.flush) begin
            head_next_s = tail_r;
        end else begin
            if (SW'(bus.commit_cnt) > occ_s) begin
                head_next_s = tail_r;
            end else begin
                head_next_s = slot_ptr_t'(head_idx_s + SW'(bus.commit_cnt));
            end
            if (!full_s) begin
                tail_next_s = slot_ptr_t'(tail_idx_s + SW'(alloc_cnt_s));
            end else begin
                tail_next_s = tail_r;
            end
        end
    end

    // Head and tail pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            head_r <= head_next_s;
            tail_r <= tail_next_s;
        end
    end

`ifdef ROB_BRANCH_LIMIT_EN
    logic [BW-1:0] br_r, br_next_s;
    int            br_calc_s;

    assign br_full_s = (int'(br_r) + W) > MAX_BRANCHES;

    // Branch count: add accepted branches, subtract retired ones, floor at 0.
    always_comb begin
        br_calc_s = int'(br_r);
        if (bus.flush) begin
            br_calc_s = 0;
        end else begin
            if (!full_s) begin
                br_calc_s = br_calc_s + count_ones(32'(bus.disp_en & bus.disp_is_branch));
            end else begin
                br_calc_s = int'(br_r);
            end
            br_calc_s = br_calc_s - int'(bus.commit_br_cnt);
            if (br_calc_s < 0) begin
                br_calc_s = 0;
            end else begin
                br_calc_s = br_calc_s;
            end
        end
        br_next_s = BW'(br_calc_s);
    end

    // In-flight branch counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_r <= '0;
        end else begin
            br_r <= br_next_s;
        end
    end

    assign bus.br_inflight = br_r;
`else
    logic unused_s;
    assign unused_s        = ^bus.disp_is_branch;
    assign br_full_s       = 1'b0;
    assign bus.br_inflight = '0;
`endif

    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.free_slots = free_s;
    assign bus.head_row   = head_r.row;
    assign bus.head_bank  = head_r.bank;

    rob_alloc_ctrl_chk #(.LANES(W), .SW(SW), .CW(CW), .BW(BW)) u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (bus.flush),
        .commit_cnt    (bus.commit_cnt),
        .commit_br_cnt (bus.commit_br_cnt),
        .occ           (occ_s),
        .br_inflight   (bus.br_inflight)
    );

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: a row-mode and a packed-mode instance (W=2,
// ROB_ROWS=4, MAX_BRANCHES=4) driven with identical stimulus, each compared
// every cycle against an occupancy model built on unbounded slot counters.
module tb_rob_alloc_ctrl;

    localparam int W     = 2;
    localparam int ROWS  = 4;
    localparam int TOTAL = W * ROWS;
    localparam int MAXB  = 4;
`ifdef ROB_BRANCH_LIMIT_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    rob_alloc_ctrl_if #(.DISPATCH_WIDTH(W), .ROB_ROWS(ROWS), .MAX_BRANCHES(MAXB)) if_r ();
    rob_alloc_ctrl_if #(.DISPATCH_WIDTH(W), .ROB_ROWS(ROWS), .MAX_BRANCHES(MAXB)) if_p ();

    rob_alloc_ctrl #(.DISPATCH_WIDTH(W), .ROB_ROWS(ROWS), .COMPACT(1'b0), .MAX_BRANCHES(MAXB))
        dut_row (.clk(clk), .rst_n(rst_n), .bus(if_r));
    rob_alloc_ctrl #(.DISPATCH_WIDTH(W), .ROB_ROWS(ROWS), .COMPACT(1'b1), .MAX_BRANCHES(MAXB))
        dut_pk  (.clk(clk), .rst_n(rst_n), .bus(if_p));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int note_cnt = 0;

    // Model: absolute slot counts; index 0 = row mode, 1 = packed mode.
    int m_head [2];
    int m_tail [2];
    int m_br   [2];

    logic [1:0] cur_en, cur_br;
    int         cur_ccnt, cur_cbr;
    logic       cur_fl;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_full(input int m);
        int fr;
        fr = TOTAL - (m_tail[m] - m_head[m]);
        return (fr < W) || (BR_EN && (m_br[m] + W > MAXB));
    endfunction

    task automatic check_outputs(input int m);
        logic [3:0]      fr;
        logic            fu, em, hb;
        logic [1:0]      hr;
        logic [2:0]      bri;
        logic [1:0][1:0] ra;
        logic [1:0]      ba;
        string           p;
        int              occ, hs, k, s;
        if (m == 0) begin
            fr = if_r.free_slots; fu = if_r.full; em = if_r.empty; hr = if_r.head_row;
            hb = if_r.head_bank; bri = if_r.br_inflight; ra = if_r.alloc_rob_addr; ba = if_r.alloc_bank_addr;
            p = "rw";
        end else begin
            fr = if_p.free_slots; fu = if_p.full; em = if_p.empty; hr = if_p.head_row;
            hb = if_p.head_bank; bri = if_p.br_inflight; ra = if_p.alloc_rob_addr; ba = if_p.alloc_bank_addr;
            p = "pk";
        end
        occ = m_tail[m] - m_head[m];
        hs  = m_head[m] % TOTAL;
        check_val({p, "_free"}, 32'(fr), 32'(TOTAL - occ));
        check_val({p, "_full"}, 32'(fu), 32'(m_full(m)));
        check_val({p, "_empty"}, 32'(em), 32'(occ == 0));
        check_val({p, "_head_row"}, 32'(hr), 32'(hs / W));
        check_val({p, "_head_bank"}, 32'(hb), 32'(hs % W));
        check_val({p, "_br"}, 32'(bri), 32'(m_br[m]));
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (m == 0) begin
                check_val({p, "_alloc_row"}, 32'(ra[i]), 32'((m_tail[m] % TOTAL) / W));
                check_val({p, "_alloc_bank"}, 32'(ba[i]), 32'(i));
            end else if (cur_en == 2'b00 || cur_en[i]) begin
                s = (cur_en == 2'b00) ? (m_tail[m] + i) % TOTAL : (m_tail[m] + k) % TOTAL;
                check_val({p, "_alloc_row"}, 32'(ra[i]), 32'(s / W));
                check_val({p, "_alloc_bank"}, 32'(ba[i]), 32'(s % W));
                k++;
            end
        end
    endtask

    task automatic model_step(input int m);
        bit f;
        int occ, alloc, nbr;
        f     = m_full(m);
        occ   = m_tail[m] - m_head[m];
        alloc = 0;
        nbr   = 0;
        if (cur_fl) begin
            m_head[m] = m_tail[m];
            m_br[m]   = 0;
        end else begin
            if (!f) begin
                if (m == 1) alloc = $countones(cur_en);
                else        alloc = (cur_en != 2'b00) ? W : 0;
                nbr = $countones(cur_en & cur_br);
            end
            m_head[m] = m_head[m] + ((cur_ccnt > occ) ? occ : cur_ccnt);
            m_tail[m] = m_tail[m] + alloc;
            if (BR_EN) begin
                m_br[m] = m_br[m] + nbr - cur_cbr;
                if (m_br[m] < 0) m_br[m] = 0;
            end
        end
    endtask

    task automatic apply(input logic [1:0] en, input logic [1:0] br,
                         input int ccnt, input int cbr, input logic fl);
        cur_en = en; cur_br = br; cur_ccnt = ccnt; cur_cbr = cbr; cur_fl = fl;
        if_r.disp_en = en; if_r.disp_is_branch = br; if_r.commit_cnt = 2'(ccnt);
        if_r.commit_br_cnt = 2'(cbr); if_r.flush = fl;
        if_p.disp_en = en; if_p.disp_is_branch = br; if_p.commit_cnt = 2'(ccnt);
        if_p.commit_br_cnt = 2'(cbr); if_p.flush = fl;
        #1;
        if (en != 2'b00 && (m_full(0) || m_full(1))) note_cnt++;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic advance();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        cur_en = 2'b00; cur_br = 2'b00; cur_ccnt = 0; cur_cbr = 0; cur_fl = 1'b0;
        if_r.disp_en = 2'b00; if_r.disp_is_branch = 2'b00; if_r.commit_cnt = 2'd0;
        if_r.commit_br_cnt = 2'd0; if_r.flush = 1'b0;
        if_p.disp_en = 2'b00; if_p.disp_is_branch = 2'b00; if_p.commit_cnt = 2'd0;
        if_p.commit_br_cnt = 2'd0; if_p.flush = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_head[m] = 0; m_tail[m] = 0; m_br[m] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int occ_min, hi, cbr_hi;
        logic [1:0] en, br;
        int ccnt, cbr;

        // 1: reset state
        reset_all();
        apply(2'b00, 2'b00, 0, 0, 1'b0);
        check_val("t1_free", 32'(if_r.free_slots), 32'd8);
        check_val("t1_empty", 32'(if_r.empty), 32'd1);
        check_val("t1_full", 32'(if_r.full), 32'd0);
        check_val("t1_bank0", 32'(if_r.alloc_bank_addr[0]), 32'd0);
        check_val("t1_bank1", 32'(if_r.alloc_bank_addr[1]), 32'd1);
        check_val("t1_row0", 32'(if_r.alloc_rob_addr[0]), 32'd0);
        check_val("t1_row1", 32'(if_r.alloc_rob_addr[1]), 32'd0);
        check_val("t1_pk_bank1", 32'(if_p.alloc_bank_addr[1]), 32'd1);
        advance();

        // 2: row mode, lane 0 only, four rows then an ignored dispatch
        for (int c = 0; c < 4; c++) begin
            apply(2'b01, 2'b00, 0, 0, 1'b0);
            check_val("t2_row", 32'(if_r.alloc_rob_addr[0]), 32'(c));
            check_val("t2_bank", 32'(if_r.alloc_bank_addr[0]), 32'd0);
            advance();
        end
        check_val("t2_full", 32'(if_r.full), 32'd1);
        check_val("t2_free", 32'(if_r.free_slots), 32'd0);
        apply(2'b01, 2'b00, 0, 0, 1'b0);
        advance();
        check_val("t2_ignored_free", 32'(if_r.free_slots), 32'd0);
        check_val("t2_ignored_head", 32'(if_r.head_row), 32'd0);

        // 3: packed mode lane packing
        reset_all();
        apply(2'b10, 2'b00, 0, 0, 1'b0);
        check_val("t3_l1_row", 32'(if_p.alloc_rob_addr[1]), 32'd0);
        check_val("t3_l1_bank", 32'(if_p.alloc_bank_addr[1]), 32'd0);
        advance();
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        check_val("t3_l0_row", 32'(if_p.alloc_rob_addr[0]), 32'd0);
        check_val("t3_l0_bank", 32'(if_p.alloc_bank_addr[0]), 32'd1);
        check_val("t3_l1b_row", 32'(if_p.alloc_rob_addr[1]), 32'd1);
        check_val("t3_l1b_bank", 32'(if_p.alloc_bank_addr[1]), 32'd0);
        advance();
        check_val("t3_free", 32'(if_p.free_slots), 32'd5);

        // 4: packed fill to one free slot, commit frees it one cycle later
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        advance();
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        advance();
        check_val("t4_free", 32'(if_p.free_slots), 32'd1);
        check_val("t4_full", 32'(if_p.full), 32'd1);
        apply(2'b00, 2'b00, 2, 0, 1'b0);
        check_val("t4_full_same_cycle", 32'(if_p.full), 32'd1);
        advance();
        check_val("t4_full_next", 32'(if_p.full), 32'd0);
        check_val("t4_free_next", 32'(if_p.free_slots), 32'd3);

        // 5: wrap-around, two in and two out per cycle
        reset_all();
        for (int c = 0; c < 10; c++) begin
            apply(2'b11, 2'b00, (c == 0) ? 0 : 2, 0, 1'b0);
            if (c == 3) check_val("t5_row3", 32'(if_p.alloc_rob_addr[0]), 32'd3);
            if (c == 4) begin
                check_val("t5_row_wrap", 32'(if_p.alloc_rob_addr[0]), 32'd0);
                check_val("t5_free_wrap", 32'(if_p.free_slots), 32'd6);
            end
            advance();
        end
        apply(2'b00, 2'b00, 2, 0, 1'b0);
        advance();
        check_val("t5_empty_pk", 32'(if_p.empty), 32'd1);
        check_val("t5_empty_rw", 32'(if_r.empty), 32'd1);

        // 6: flush beats same-cycle dispatch and commit
        reset_all();
        apply(2'b11, 2'b11, 0, 0, 1'b0);
        advance();
        apply(2'b01, 2'b01, 0, 0, 1'b0);
        advance();
`ifdef ROB_BRANCH_LIMIT_EN
        check_val("t6_br3", 32'(if_p.br_inflight), 32'd3);
        check_val("t6_br_full", 32'(if_p.full), 32'd1);
`endif
        apply(2'b11, 2'b00, 1, 0, 1'b1);
        advance();
        check_val("t6_empty_rw", 32'(if_r.empty), 32'd1);
        check_val("t6_empty_pk", 32'(if_p.empty), 32'd1);
        check_val("t6_free", 32'(if_p.free_slots), 32'd8);
        check_val("t6_br", 32'(if_p.br_inflight), 32'd0);
        check_val("t6_head_rw", 32'(if_r.head_row), 32'd2);
        check_val("t6_head_pk_row", 32'(if_p.head_row), 32'd1);
        check_val("t6_head_pk_bank", 32'(if_p.head_bank), 32'd1);

        // Randomised legal traffic against the model
        reset_all();
        for (int c = 0; c < 400; c++) begin
            en      = 2'($urandom_range(0, 3));
            br      = 2'($urandom_range(0, 3)) & en;
            occ_min = m_tail[0] - m_head[0];
            if (m_tail[1] - m_head[1] < occ_min) occ_min = m_tail[1] - m_head[1];
            hi      = (occ_min < W) ? occ_min : W;
            ccnt    = $urandom_range(0, hi);
            cbr_hi  = ccnt;
            if (BR_EN) begin
                if (m_br[0] < cbr_hi) cbr_hi = m_br[0];
                if (m_br[1] < cbr_hi) cbr_hi = m_br[1];
            end
            cbr = $urandom_range(0, cbr_hi);
            apply(en, br, ccnt, cbr, ($urandom_range(0, 15) == 0));
            advance();
        end

        $display("note: %0d dispatch attempts made while full were dropped", note_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
